stage_f: RTL and testbench
==========================

STAGE_F -- requirements
Module: stage_f

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port arm, input, 1 bit: 1 selects ARM redirect, 0 selects RISC-V redirect.
REQ-006 The block SHALL have port stallF, input, 1 bit, hazard-unit hold of the PC.
REQ-007 The block SHALL have port PCSrcE, input, 1 bit, RISC-V branch/jump taken.
REQ-008 The block SHALL have port PCTargetE, input, 32 bits, RISC-V redirect target.
REQ-009 The block SHALL have port PCSrcW, input, 1 bit, ARM write to r15.
REQ-010 The block SHALL have port ResultW, input, 32 bits, ARM redirect target.
REQ-011 The block SHALL have port imem_req, output, 1 bit, request valid.
REQ-012 The block SHALL have port imem_addr, output, 32 bits, request address.
REQ-013 The block SHALL have port imem_gnt, input, 1 bit, request accepted this cycle.
REQ-014 The block SHALL have port imem_rvalid, input, 1 bit, response valid.
REQ-015 The block SHALL have port imem_rdata, input, 32 bits, response word.
REQ-016 The block SHALL have port RDD, output, 32 bits, instruction to decode.
REQ-017 The block SHALL have port PCF, output, 32 bits, current fetch PC.
REQ-018 The block SHALL have port PCPlus4F, output, 32 bits, PCF+4.
REQ-019 The block SHALL have port fetch_stall, output, 1 bit, high while the instruction at PCF is not yet buffered.
REQ-020 The block SHALL have port fetch_err, output, 1 bit, sticky protocol-error flag.

Function
REQ-021 PCPlus4F SHALL equal PCF+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-022 redirect SHALL be PCSrcW when arm=1 and PCSrcE when arm=0; the unselected source SHALL be ignored.
REQ-023 The redirect target SHALL be ResultW when arm=1 and PCTargetE when arm=0.
REQ-024 The FSM SHALL have four states: REQ, WAIT, DROP and HAVE.
REQ-025 In REQ the block SHALL drive imem_req=1 and imem_addr=PCF.
REQ-026 In REQ with imem_gnt=1 the FSM SHALL go to WAIT, or to DROP if redirect=1 in the same cycle.
REQ-027 In REQ with no grant, a redirect SHALL update PCF while the FSM stays in REQ; imem_addr MAY change before grant.
REQ-028 In WAIT with imem_rvalid=1 and no redirect, the block SHALL capture imem_rdata into instr_buf and go to HAVE.
REQ-029 In WAIT with redirect=1 the FSM SHALL go to REQ if imem_rvalid=1 in the same cycle (response discarded), else to DROP.
REQ-030 In DROP, imem_rvalid=1 SHALL discard the response and move the FSM to REQ; a redirect in DROP SHALL update PCF only.
REQ-031 In HAVE with redirect=1, PCF SHALL load the target and the FSM SHALL go to REQ; redirect overrides stallF.
REQ-032 In HAVE with stallF=0 and no redirect, PCF SHALL load PCPlus4F and the FSM SHALL go to REQ.
REQ-033 In HAVE with stallF=1 and no redirect, PCF, state and instr_buf SHALL hold.
REQ-034 A redirect SHALL always load PCF on the same clock edge, in every state.
REQ-035 fetch_stall SHALL be 1 in every state except HAVE.
REQ-036 RDD SHALL be instr_buf in HAVE and 32'h0000_0000 otherwise.
REQ-037 imem_rvalid in REQ or HAVE SHALL set fetch_err, which stays set until reset; the response SHALL be ignored.
REQ-038 At most one request SHALL be outstanding; minimum latency is grant to rvalid of one cycle, giving 1 instruction per 3 cycles.

Reset
REQ-039 On rst the block SHALL asynchronously set PCF=RESET_PC, state=REQ, instr_buf=0 and fetch_err=0.
REQ-040 While rst=1 and in the first cycle after release, the block SHALL drive imem_req=1 and imem_addr=RESET_PC.
REQ-041 A reset mid-operation SHALL abandon any outstanding request; the instruction memory is reset from the same rst.

Structure
REQ-042 The shared package combi_pkg SHALL hold fetch_state_t (REQ, WAIT, DROP, HAVE), the NOP constant 32'h0 and the PC width.
REQ-043 The state machine SHALL be the sub-module stage_f_fsm; the PC register, redirect mux and instr_buf SHALL stay in stage_f.

Verification
REQ-044 The bench SHALL cover reset release with zero-latency memory -> fetch at 0, 4, 8; RDD valid every 3rd cycle; PCPlus4F=PCF+4.
REQ-045 The bench SHALL cover RISC-V PCSrcE=1, PCTargetE=32'h100 while in WAIT -> DROP; the stale word is never on RDD; the next request is to 32'h100.
REQ-046 The bench SHALL cover ARM arm=1, PCSrcW=1, ResultW=32'h40 in HAVE with stallF=1 -> PCF=32'h40 next cycle, state REQ.
REQ-047 The bench SHALL cover stallF=1 for 5 cycles in HAVE -> RDD, PCF and fetch_stall=0 all constant; no imem_req.
REQ-048 The bench SHALL cover arm=0 with PCSrcW=1 -> no redirect; and unsolicited imem_rvalid in HAVE -> fetch_err=1 until rst.
REQ-049 The bench SHALL cover rst asserted in WAIT -> PCF=RESET_PC immediately and state REQ; PCF=32'hFFFF_FFFC -> PCPlus4F=0.

Source files
------------

// File: rtl/combi_pkg.sv
// combi_pkg: shared fetch-stage types and constants
package combi_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP = '0;
  typedef enum logic [1:0] {REQ, WAIT, DROP, HAVE} fetch_state_t;
endpackage

// File: rtl/stage_f_fsm.sv
// stage_f_fsm: single-outstanding instruction fetch request/response sequencer
module stage_f_fsm
  import combi_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect,
  input  logic         stall,
  input  logic         gnt,
  input  logic         rvalid,
  output fetch_state_t state,
  output logic         capture,
  output logic         err_set
);
  fetch_state_t state_q, state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= REQ;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    err_set = 1'b0;
    case (state_q)
      REQ: begin
        err_set = rvalid;
        if (gnt) state_d = redirect ? DROP : WAIT;
      end
      WAIT: begin
        capture = rvalid && !redirect;
        if (rvalid) state_d = redirect ? REQ : HAVE;
        else if (redirect) state_d = DROP;
      end
      DROP: if (rvalid) state_d = REQ;
      HAVE: begin
        err_set = rvalid;
        if (redirect || !stall) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end
  assign state = state_q;
endmodule

// File: rtl/stage_f.sv
// stage_f: fetch stage with PC register, ARM/RISC-V redirect mux and instruction buffer
module stage_f
  import combi_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            stallF,
  input  logic            PCSrcE,
  input  logic [PC_W-1:0] PCTargetE,
  input  logic            PCSrcW,
  input  logic [PC_W-1:0] ResultW,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] RDD,
  output logic [PC_W-1:0] PCF,
  output logic [PC_W-1:0] PCPlus4F,
  output logic            fetch_stall,
  output logic            fetch_err
);
  fetch_state_t state;
  logic capture, err_set, redirect, have;
  logic [PC_W-1:0] target, pc_q, pc_d, buf_q, buf_d;
  logic err_q, err_d;
  stage_f_fsm u_fsm (
    .clk(clk), .rst(rst), .redirect(redirect), .stall(stallF),
    .gnt(imem_gnt), .rvalid(imem_rvalid),
    .state(state), .capture(capture), .err_set(err_set)
  );
  always_comb begin
    redirect = arm ? PCSrcW : PCSrcE;
    target   = arm ? ResultW : PCTargetE;
    have     = state == HAVE;
    PCPlus4F = pc_q + 32'd4;
    pc_d     = redirect ? target : (have && !stallF) ? PCPlus4F : pc_q;
    buf_d    = capture ? imem_rdata : buf_q;
    err_d    = err_q | err_set;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q  <= RESET_PC;
      buf_q <= NOP;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      buf_q <= buf_d;
      err_q <= err_d;
    end
  assign imem_req    = state == REQ;
  assign imem_addr   = pc_q;
  assign PCF         = pc_q;
  assign RDD         = have ? buf_q : NOP;
  assign fetch_stall = !have;
  assign fetch_err   = err_q;
endmodule

// File: tb/tb_stage_f.sv
// tb_stage_f: table, directed and randomized checks of stage_f against a flag-based reference
module tb_stage_f;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic arm = 0, stallF = 0, PCSrcE = 0, PCSrcW = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] PCTargetE = 0, ResultW = 0, imem_rdata = 0;
  logic imem_req, fetch_stall, fetch_err;
  logic [31:0] imem_addr, RDD, PCF, PCPlus4F;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_buf, mem_addr;
  bit m_pend, m_drop, m_have, m_err, mem_pend;
  logic [31:0] save_rdd, save_pc;
  typedef struct {
    bit gnt; bit rv; logic [31:0] rd;
    logic [31:0] pcf; bit req; bit st; logic [31:0] rdd;
  } vec_t;
  vec_t tbl[9];

  stage_f #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stallF(stallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .RDD(RDD), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .fetch_stall(fetch_stall), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_pend && !m_have});
    chk("imem_addr", imem_addr, m_pc);
    chk("PCF", PCF, m_pc);
    chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    chk("RDD", RDD, m_have ? m_buf : 32'h0);
    chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, !m_have});
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_buf = 0; m_pend = 0; m_drop = 0; m_have = 0; m_err = 0;
    mem_pend = 0;
  endtask

  task automatic tick();
    bit r, n_pend, n_drop, n_have, n_err, n_mp;
    logic [31:0] t, n_pc, n_buf, n_ma;
    r = arm ? PCSrcW : PCSrcE;
    t = arm ? ResultW : PCTargetE;
    n_pc = m_pc; n_buf = m_buf; n_pend = m_pend; n_drop = m_drop; n_have = m_have; n_err = m_err;
    if (m_have) begin
      if (imem_rvalid) n_err = 1;
      if (r) begin n_pc = t; n_have = 0; end
      else if (!stallF) begin n_pc = m_pc + 32'd4; n_have = 0; end
    end else if (!m_pend) begin
      if (imem_rvalid) n_err = 1;
      if (imem_gnt) begin n_pend = 1; n_drop = r; end
      if (r) n_pc = t;
    end else begin
      if (r) n_pc = t;
      if (imem_rvalid) begin
        n_pend = 0;
        if (!m_drop && !r) begin n_have = 1; n_buf = imem_rdata; end
      end else if (r) n_drop = 1;
    end
    n_mp = mem_pend && !imem_rvalid;
    n_ma = mem_addr;
    if (imem_req && imem_gnt) begin n_mp = 1; n_ma = imem_addr; end
    @(posedge clk);
    m_pc = n_pc; m_buf = n_buf; m_pend = n_pend; m_drop = n_drop; m_have = n_have; m_err = n_err;
    mem_pend = n_mp; mem_addr = n_ma;
    #1;
  endtask

  task automatic idle();
    arm = 0; stallF = 0; PCSrcE = 0; PCSrcW = 0; imem_gnt = 0; imem_rvalid = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1 model_reset();
    chk("rst_PCF", PCF, RESET_PC);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    check_all();
    @(posedge clk);
    #1 rst = 0;
    check_all();
  endtask

  initial begin
    model_reset();
    tbl[0] = '{1'b1, 1'b0, 32'h0,         32'h0, 1'b1, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'hAAAA_0000, 32'h0, 1'b0, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 32'hAAAA_0000};
    tbl[3] = '{1'b1, 1'b0, 32'h0,         32'h4, 1'b1, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'hAAAA_0004, 32'h4, 1'b0, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,         32'h4, 1'b0, 1'b0, 32'hAAAA_0004};
    tbl[6] = '{1'b1, 1'b0, 32'h0,         32'h8, 1'b1, 1'b1, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 32'hAAAA_0008, 32'h8, 1'b0, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 1'b0, 32'h0,         32'h8, 1'b0, 1'b0, 32'hAAAA_0008};
    #1 check_all();
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 9; i++) begin
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
      chk("tbl_PCF", PCF, tbl[i].pcf);
      chk("tbl_PCPlus4F", PCPlus4F, tbl[i].pcf + 32'd4);
      chk("tbl_req", {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk("tbl_stall", {31'b0, fetch_stall}, {31'b0, tbl[i].st});
      chk("tbl_RDD", RDD, tbl[i].rdd);
      check_all();
      tick();
    end
    idle();
    do_reset();
    imem_gnt = 1; tick(); imem_gnt = 0;
    PCSrcE = 1; PCTargetE = 32'h100; tick(); PCSrcE = 0;
    chk("wait_redir_PCF", PCF, 32'h100);
    chk("drop_req", {31'b0, imem_req}, 32'd0);
    chk("drop_RDD", RDD, 32'h0);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 0;
    chk("after_drop_req", {31'b0, imem_req}, 32'd1);
    chk("after_drop_addr", imem_addr, 32'h100);
    chk("stale_RDD", RDD, 32'h0);
    check_all();
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'hCAFE_0100; tick(); imem_rvalid = 0;
    chk("fresh_RDD", RDD, 32'hCAFE_0100);
    stallF = 1; arm = 1; PCSrcW = 1; ResultW = 32'h40; tick(); PCSrcW = 0;
    chk("arm_redir_PCF", PCF, 32'h40);
    chk("arm_redir_req", {31'b0, imem_req}, 32'd1);
    check_all();
    arm = 0; stallF = 0;
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h1234_0040; tick(); imem_rvalid = 0;
    stallF = 1;
    save_rdd = RDD; save_pc = PCF;
    chk("hold_start_RDD", save_rdd, 32'h1234_0040);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_RDD", RDD, save_rdd);
      chk("hold_PCF", PCF, save_pc);
      chk("hold_stall", {31'b0, fetch_stall}, 32'd0);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
    end
    PCSrcW = 1; ResultW = 32'h999; tick(); PCSrcW = 0;
    chk("unsel_PCF", PCF, 32'h40);
    imem_rvalid = 1; imem_rdata = 32'h5555_5555; tick(); imem_rvalid = 0;
    chk("err_set", {31'b0, fetch_err}, 32'd1);
    chk("err_RDD", RDD, 32'h1234_0040);
    stallF = 0;
    repeat (4) tick();
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);
    check_all();
    do_reset();
    chk("err_clear", {31'b0, fetch_err}, 32'd0);
    PCSrcE = 1; PCTargetE = 32'h200; tick(); PCSrcE = 0;
    imem_gnt = 1; tick(); imem_gnt = 0;
    tick();
    do_reset();
    chk("wait_rst_req", {31'b0, imem_req}, 32'd1);
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC; tick(); PCSrcE = 0;
    chk("wrap_PCF", PCF, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4F", PCPlus4F, 32'h0);
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h7777_0000; tick(); imem_rvalid = 0;
    tick();
    chk("wrap_next_PCF", PCF, 32'h0);
    check_all();
    idle();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) begin idle(); do_reset(); end
      arm = 1'($urandom);
      PCSrcE = ($urandom % 8) == 0;
      PCSrcW = ($urandom % 8) == 0;
      PCTargetE = $urandom & 32'hFFFF_FFFC;
      ResultW = $urandom & 32'hFFFF_FFFC;
      stallF = ($urandom % 3) == 0;
      imem_gnt = imem_req && ($urandom % 2 == 0);
      imem_rvalid = mem_pend ? ($urandom % 2 == 0) : ($urandom % 200 == 0);
      imem_rdata = mem_pend ? (mem_addr ^ 32'hA5A5_0000) : $urandom;
      check_all();
      tick();
    end
    idle();
    check_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
